coeff_pack_3533: RTL



---
 rtl/coeff_pack_3533.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/coeff_pack_3533.sv
// coeff_pack_3533: packs reduced 12-bit coefficients (two per three bytes)
// into a valid/ready byte stream, with sticky range and length error flags.
//
//   state  | meaning
//   S_GET0 | wait for / pop first coefficient of a pair (c0)
//   S_GET1 | wait for / pop second coefficient of a pair (c1)
//   S_B0   | present c0[7:0]
//   S_B1   | present {c1[3:0], c0[11:8]}
//   S_B2   | present c1[11:4]; carries dout_last for a final pair
module coeff_pack_3533 #(
    parameter int unsigned Q     = 3533,
    parameter int unsigned N     = 256,
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic [11:0] din_coef,
    input  logic        din_last,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic [7:0]  dout_byte,
    output logic        dout_last,
    input  logic        err_clr,
    output logic        err_range,
    output logic        err_len
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned LW = $clog2(N);

    localparam logic [11:0]   Q_C     = 12'(Q);
    localparam logic [LW-1:0] LEN_MAX = LW'(N - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_GET0,
        S_GET1,
        S_B0,
        S_B1,
        S_B2
    } state_t;

    state_t state_q, state_d;

    logic          din_ready_q;
    logic          accept;

    // Accepted coefficients land in a one-entry staging register before the
    // FIFO; it is counted as FIFO occupancy so total buffering stays DEPTH.
    logic          stg_vld_q;
    logic [12:0]   stg_data_q;

    logic [12:0]   fifo_mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [CW-1:0] occ_d;
    logic          fifo_empty;
    logic [12:0]   fifo_head;
    logic          pop;

    logic [11:0]   c0_q, c0_d;
    logic [11:0]   c1_q, c1_d;
    logic          last_q, last_d;

    logic [LW-1:0] len_q, len_d;
    logic          err_range_q, err_range_d;
    logic          err_len_q, err_len_d;

    assign accept     = din_valid && din_ready_q;
    assign din_ready  = din_ready_q;
    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_head  = fifo_mem_q[rd_ptr_q];
    assign err_range  = err_range_q;
    assign err_len    = err_len_q;

    // Staging register: holds the coefficient accepted on the previous edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_vld_q  <= 1'b0;
            stg_data_q <= '0;
        end else begin
            stg_vld_q <= accept;
            if (accept) begin
                stg_data_q <= {din_last, din_coef};
            end
        end
    end

    // FIFO storage; a staged entry always fits because occupancy includes it.
    always_ff @(posedge clk) begin
        if (stg_vld_q) begin
            fifo_mem_q[wr_ptr_q] <= stg_data_q;
        end
    end

    // Occupancy bookkeeping and the registered ready flag.
    always_comb begin
        fifo_cnt_d = fifo_cnt_q + CW'(stg_vld_q) - CW'(pop);
        occ_d      = fifo_cnt_d + CW'(accept);
    end

    // FIFO pointers, count and din_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            din_ready_q <= 1'b0;
        end else begin
            if (stg_vld_q) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            fifo_cnt_q  <= fifo_cnt_d;
            din_ready_q <= (occ_d < DEPTH_C);
        end
    end

    // FSM state and pair registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_GET0;
            c0_q    <= '0;
            c1_q    <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c0_q    <= c0_d;
            c1_q    <= c1_d;
            last_q  <= last_d;
        end
    end

    // FSM next state, FIFO pop and byte output decode.
    always_comb begin
        state_d    = state_q;
        c0_d       = c0_q;
        c1_d       = c1_q;
        last_d     = last_q;
        pop        = 1'b0;
        dout_valid = 1'b0;
        dout_byte  = 8'h00;
        dout_last  = 1'b0;
        case (state_q)
            S_GET0: begin
                if (!fifo_empty) begin
                    pop    = 1'b1;
                    c0_d   = fifo_head[11:0];
                    last_d = fifo_head[12];
                    if (fifo_head[12]) begin
                        // odd-length polynomial: pad the missing c1 with zero
                        c1_d    = '0;
                        state_d = S_B0;
                    end else begin
                        state_d = S_GET1;
                    end
                end
            end
            S_GET1: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    c1_d    = fifo_head[11:0];
                    last_d  = fifo_head[12];
                    state_d = S_B0;
                end
            end
            S_B0: begin
                dout_valid = 1'b1;
                dout_byte  = c0_q[7:0];
                if (dout_ready) state_d = S_B1;
            end
            S_B1: begin
                dout_valid = 1'b1;
                dout_byte  = {c1_q[3:0], c0_q[11:8]};
                if (dout_ready) state_d = S_B2;
            end
            S_B2: begin
                dout_valid = 1'b1;
                dout_byte  = c1_q[11:4];
                dout_last  = last_q;
                if (dout_ready) state_d = S_GET0;
            end
            default: state_d = S_GET0;
        endcase
    end

    // Error flags and polynomial length counter; a new error beats err_clr.
    always_comb begin
        err_range_d = err_range_q && !err_clr;
        err_len_d   = err_len_q && !err_clr;
        len_d       = len_q;
        if (accept) begin
            if (din_coef >= Q_C) begin
                err_range_d = 1'b1;
            end
            if (len_q == LEN_MAX) begin
                len_d = '0;
                if (!din_last) err_len_d = 1'b1;
            end else if (din_last) begin
                len_d     = '0;
                err_len_d = 1'b1;
            end else begin
                len_d = len_q + LW'(1);
            end
        end
    end

    // Error and length registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_range_q <= 1'b0;
            err_len_q   <= 1'b0;
            len_q       <= '0;
        end else begin
            err_range_q <= err_range_d;
            err_len_q   <= err_len_d;
            len_q       <= len_d;
        end
    end

endmodule
